// File: rtl/armleocpu_simple_bus_arbiter.sv
// Round-robin arbiter: N valid/ready requesters share one simple-bus
// peripheral port, one transaction outstanding, registered response.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   req_valid/ready     per-requester request handshake
//   req_write/address   packed request payload (address, wdata, wstrb)
//   req_wdata/wstrb
//   rsp_valid/ready     per-requester response handshake
//   rsp_rdata/rsp_resp  shared registered response (00 OK, 10 SLVERR, 11 DECERR)
//   address, write,     simple-bus master side
//   write_data, write_byteenable, read
//   read_data, address_error, write_error   simple-bus slave returns
module armleocpu_simple_bus_arbiter #(
    parameter int N          = 2,
    parameter int ADDR_WIDTH = 34
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req_valid,
    output logic [N-1:0]            req_ready,
    input  logic [N-1:0]            req_write,
    input  logic [N*ADDR_WIDTH-1:0] req_address,
    input  logic [N*32-1:0]         req_wdata,
    input  logic [N*4-1:0]          req_wstrb,
    output logic [N-1:0]            rsp_valid,
    input  logic [N-1:0]            rsp_ready,
    output logic [31:0]             rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    write,
    output logic [31:0]             write_data,
    output logic [3:0]              write_byteenable,
    output logic                    read,
    input  logic [31:0]             read_data,
    input  logic                    address_error,
    input  logic                    write_error
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RESPOND
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          found;
    logic          accept;
    logic [1:0]    resp_next;

    // Scan starts just after the last winner, so it becomes lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // rst_n gating keeps handshakes and strobes quiet while reset is held.
    assign accept = (state == IDLE) && found && rst_n;

    // With no winner, winner is 0, so the bus shows requester 0's payload.
    always_comb begin
        req_ready        = '0;
        address          = req_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
        write_data       = req_wdata[winner*32 +: 32];
        write_byteenable = req_wstrb[winner*4 +: 4];
        write            = accept && req_write[winner];
        read             = accept && !req_write[winner];
        if (accept) begin
            req_ready = N'(1) << winner;
        end
    end

    // Strobe still goes out on error; the slave is expected to ignore it.
    always_comb begin
        resp_next = 2'b00;
        if (address_error) begin
            resp_next = 2'b11;
        end else if (req_write[winner] && write_error) begin
            resp_next = 2'b10;
        end else if (address[1:0] != 2'b00) begin
            resp_next = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= IW'(N - 1);
            gnt_idx   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_idx   <= winner;
                        rr_ptr    <= winner;
                        rsp_rdata <= req_write[winner] ? 32'd0 : read_data;
                        rsp_resp  <= resp_next;
                        rsp_valid <= N'(1) << winner;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_simple_bus_arbiter.sv
// Directed bench for armleocpu_simple_bus_arbiter: N=2 instance for the
// main scenarios plus an N=4 instance for rotation with sparse requesters.
module tb_armleocpu_simple_bus_arbiter;

    localparam int AW = 34;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sbq[$];

    // N=2 instance signals
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [1:0]      req_write = '0;
    logic [2*AW-1:0] req_address = '0;
    logic [63:0]     req_wdata = '0;
    logic [7:0]      req_wstrb = '0;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = '0;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   address;
    logic            write;
    logic [31:0]     write_data;
    logic [3:0]      write_byteenable;
    logic            read;
    logic [31:0]     read_data = '0;
    logic            address_error = 1'b0;
    logic            write_error = 1'b0;

    // N=4 instance signals
    logic [3:0]      b_req_valid = '0;
    logic [3:0]      b_req_ready;
    logic [3:0]      b_req_write = '0;
    logic [4*AW-1:0] b_req_address = '0;
    logic [127:0]    b_req_wdata = '0;
    logic [15:0]     b_req_wstrb = '0;
    logic [3:0]      b_rsp_valid;
    logic [3:0]      b_rsp_ready = '0;
    logic [31:0]     b_rsp_rdata;
    logic [1:0]      b_rsp_resp;
    logic [AW-1:0]   b_address;
    logic            b_write;
    logic [31:0]     b_write_data;
    logic [3:0]      b_write_byteenable;
    logic            b_read;

    armleocpu_simple_bus_arbiter #(.N(2), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_address(req_address),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .address(address), .write(write),
        .write_data(write_data), .write_byteenable(write_byteenable),
        .read(read), .read_data(read_data),
        .address_error(address_error), .write_error(write_error)
    );

    armleocpu_simple_bus_arbiter #(.N(4), .ADDR_WIDTH(AW)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_address(b_req_address),
        .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_resp(b_rsp_resp),
        .address(b_address), .write(b_write),
        .write_data(b_write_data), .write_byteenable(b_write_byteenable),
        .read(b_read), .read_data(32'h0),
        .address_error(1'b0), .write_error(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(req_ready) && $onehot0(rsp_valid) && !(write && read)
                && $onehot0(b_req_ready) && $onehot0(b_rsp_valid)
                && !(b_write && b_read)) else begin
            errors++;
            $error("FAIL protocol rr=%b rv=%b w=%b r=%b brr=%b brv=%b",
                   req_ready, rsp_valid, write, read, b_req_ready, b_rsp_valid);
        end
    end

    // Caller must be just after a posedge. Returns just after the accept edge.
    task automatic issue(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] rd, input bit aerr, input bit werr,
                         output int waited);
        exp_t e;
        bit got;
        got = 1'b0;
        waited = 0;
        req_write[i] = wr;
        req_address[i*AW +: AW] = a;
        req_wdata[i*32 +: 32] = wd;
        req_wstrb[i*4 +: 4] = ws;
        read_data = rd;
        address_error = aerr;
        write_error = werr;
        req_valid[i] = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
            else waited++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req=%0d", i);
        end else begin
            chk("req_ready", req_ready, 64'(1) << i);
            chk("write_strobe", write, wr);
            chk("read_strobe", read, !wr);
            chk("address", address, a);
            if (wr) begin
                chk("write_data", write_data, wd);
                chk("byteenable", write_byteenable, ws);
            end
            e.idx = i;
            e.rdata = wr ? 32'd0 : rd;
            e.resp = aerr ? 2'b11 :
                     (wr && werr) ? 2'b10 :
                     (a[1:0] != 2'b00) ? 2'b10 : 2'b00;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        read_data = '0;
        address_error = 1'b0;
        write_error = 1'b0;
    endtask

    // Holds rsp_ready low for 'hold' cycles, then completes the response.
    task automatic respond(input int hold);
        exp_t e;
        logic [1:0] ev;
        bit got;
        int waited;
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (|rsp_valid) got = 1'b1;
            else waited++;
        end
        if (!got || sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout got=%0d queued=%0d", got, sbq.size());
        end else begin
            e = sbq.pop_front();
            ev = 2'b01 << e.idx;
            chk("rsp_latency", waited, 0);
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("strobes_off", {write, read}, 2'b00);
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", rsp_valid, ev);
                chk("hold_rdata", rsp_rdata, e.rdata);
                chk("hold_resp", rsp_resp, e.resp);
                chk("hold_ready", req_ready, 2'b00);
            end
            rsp_ready = ev;
            @(posedge clk);
            #1;
            rsp_ready = '0;
            @(negedge clk);
            chk("rsp_done", rsp_valid, 2'b00);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] exp_rr;
        logic [3:0] exp_rv;

        // Reset state, with both requesters already asserting
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        read_data = 32'hA5A5A5A5;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_rsp_valid", rsp_valid, 2'b00);
        chk("reset_strobes", {write, read}, 2'b00);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_resp", rsp_resp, 2'b00);

        // Continuous contention: grants alternate 0,1,0,1 every other cycle
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            exp_rr = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 2)) : 4'b0000;
            exp_rv = (c % 2 == 1) ? (4'b0001 << ((c / 2) % 2)) : 4'b0000;
            chk("rr_req_ready", req_ready, exp_rr[1:0]);
            chk("rr_rsp_valid", rsp_valid, exp_rv[1:0]);
            if (c % 2 == 1) chk("rr_rdata", rsp_rdata, 32'hA5A5A5A5);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rsp_ready = 2'b00;
        read_data = '0;

        // Single read with stalled response
        issue(0, 1'b0, 34'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, w);
        respond(3);

        // Rejected write to requester 1
        issue(1, 1'b1, 34'h4, 32'hCAFEF00D, 4'b0011, 32'h5555, 1'b0, 1'b1, w);
        respond(1);

        // Clean write, misaligned read, unmapped misaligned read
        issue(1, 1'b1, 34'h8, 32'h12345678, 4'b1111, 32'h0, 1'b0, 1'b0, w);
        respond(0);
        issue(0, 1'b0, 34'h6, 32'h0, 4'h0, 32'h77, 1'b0, 1'b0, w);
        respond(0);
        issue(0, 1'b0, 34'h6, 32'h0, 4'h0, 32'h88, 1'b1, 1'b0, w);
        respond(0);
        issue(1, 1'b0, 34'h3_0000_0000, 32'h0, 4'h0, 32'h99, 1'b0, 1'b0, w);
        respond(0);

        // Reset while requester 1 holds a response
        issue(1, 1'b0, 34'h20, 32'h0, 4'h0, 32'h1234, 1'b0, 1'b0, w);
        @(negedge clk);
        chk("pre_reset_rsp", rsp_valid, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("reset_drop_rsp", rsp_valid, 2'b00);
        sbq.delete();
        @(posedge clk);
        #1;
        req_write[1] = 1'b0;
        req_valid[1] = 1'b1;
        #1;
        chk("reset_hold_ready", req_ready, 2'b00);
        rst_n = 1'b1;
        issue(0, 1'b0, 34'h40, 32'h0, 4'h0, 32'h4444, 1'b0, 1'b0, w);
        req_valid[1] = 1'b0;
        chk("post_reset_first", w, 0);
        respond(0);

        // N=4: after a grant to 1, requesters 1 and 3 rotate 3,1,3
        b_req_address[1*AW +: AW] = 34'h100;
        b_req_address[3*AW +: AW] = 34'h300;
        b_rsp_ready = 4'hF;
        b_req_valid = 4'b0010;
        #1;
        chk("n4_first", b_req_ready, 4'b0010);
        @(posedge clk);
        #1;
        b_req_valid = 4'b1010;
        @(negedge clk);
        chk("n4_rsp1", b_rsp_valid, 4'b0010);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_rr = (c % 2 == 0) ? ((c % 4 == 0) ? 4'b1000 : 4'b0010) : 4'b0000;
            exp_rv = (c % 2 == 1) ? ((c % 4 == 1) ? 4'b1000 : 4'b0010) : 4'b0000;
            chk("n4_req_ready", b_req_ready, exp_rr);
            chk("n4_rsp_valid", b_rsp_valid, exp_rv);
            if (c == 0) chk("n4_address", b_address, 34'h300);
        end
        b_req_valid = 4'b0000;
        @(posedge clk);
        #1;
        b_rsp_ready = 4'h0;
        @(negedge clk);
        chk("n4_idle", b_rsp_valid, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
